// File: rtl/uart_rx_cmd_ctrl.sv
// UART command decoder: turns 0xAA/0xBB byte frames from a UART receiver into
// register-file writes and reads, and returns read data to the UART transmitter.
module uart_rx_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  RX_ERR,
  input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
  input  logic                  RF_RD_DATA_VLD,
  input  logic                  TX_BUSY,
  output logic                  RF_WR_EN,
  output logic                  RF_RD_EN,
  output logic [ADDR_WIDTH-1:0] RF_ADDR,
  output logic [DATA_WIDTH-1:0] RF_WR_DATA,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  CMD_ERR
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // The counter aborts on the cycle it would otherwise reach TIMEOUT-1.
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 2);
  localparam logic [DATA_WIDTH-1:0] CMD_WR = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD = DATA_WIDTH'(8'hBB);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_REQ
  } state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [ADDR_WIDTH-1:0]   addr_n;
  logic [DATA_WIDTH-1:0]   wdata_n, txd_n;
  logic                    wr_en_n, rd_en_n, tx_vld_n, cmd_err_n;
  logic                    good, bad, expire;

  assign good   = RX_D_VLD & ~RX_ERR;
  assign bad    = RX_D_VLD &  RX_ERR;
  assign expire = (cnt == LIMIT);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned; that is what keeps this block from inferring latches.
    state_n   = state;
    cnt_n     = '0;
    addr_n    = RF_ADDR;
    wdata_n   = RF_WR_DATA;
    txd_n     = TX_P_DATA;
    wr_en_n   = 1'b0;
    rd_en_n   = 1'b0;
    tx_vld_n  = 1'b0;
    cmd_err_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (good && RX_P_DATA == CMD_WR)      state_n = WR_ADDR;
        else if (good && RX_P_DATA == CMD_RD) state_n = RD_ADDR;
      end
      WR_ADDR, RD_ADDR: begin
        if (good) begin
          addr_n  = RX_P_DATA[ADDR_WIDTH-1:0];
          rd_en_n = (state == RD_ADDR);
          state_n = (state == RD_ADDR) ? RD_WAIT : WR_DATA;
        end else if (bad || expire) begin
          cmd_err_n = 1'b1;
          state_n   = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      WR_DATA: begin
        if (good) begin
          wdata_n = RX_P_DATA;
          wr_en_n = 1'b1;
          state_n = IDLE;
        end else if (bad || expire) begin
          cmd_err_n = 1'b1;
          state_n   = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RD_WAIT: begin
        // Received bytes are dropped here; only the register file can end the wait.
        if (RF_RD_DATA_VLD) begin
          txd_n   = RF_RD_DATA;
          state_n = TX_REQ;
        end else if (expire) begin
          cmd_err_n = 1'b1;
          state_n   = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      TX_REQ: begin
        if (!TX_BUSY) begin
          tx_vld_n = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      cnt        <= '0;
      RF_ADDR    <= '0;
      RF_WR_DATA <= '0;
      TX_P_DATA  <= '0;
      RF_WR_EN   <= 1'b0;
      RF_RD_EN   <= 1'b0;
      TX_D_VLD   <= 1'b0;
      CMD_ERR    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      RF_ADDR    <= addr_n;
      RF_WR_DATA <= wdata_n;
      TX_P_DATA  <= txd_n;
      RF_WR_EN   <= wr_en_n;
      RF_RD_EN   <= rd_en_n;
      TX_D_VLD   <= tx_vld_n;
      CMD_ERR    <= cmd_err_n;
    end
  end

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Directed bench for uart_rx_cmd_ctrl: expected strobes go into a queue as
// frames are sent and a negedge monitor pops and compares them as they appear.
module tb_uart_rx_cmd_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] RX_P_DATA = '0;
  logic       RX_D_VLD = 1'b0;
  logic       RX_ERR = 1'b0;
  logic [7:0] RF_RD_DATA = '0;
  logic       RF_RD_DATA_VLD = 1'b0;
  logic       TX_BUSY = 1'b0;
  logic       RF_WR_EN, RF_RD_EN, TX_D_VLD, CMD_ERR;
  logic [3:0] RF_ADDR;
  logic [7:0] RF_WR_DATA, TX_P_DATA;

  uart_rx_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .RX_ERR(RX_ERR),
    .RF_RD_DATA(RF_RD_DATA), .RF_RD_DATA_VLD(RF_RD_DATA_VLD), .TX_BUSY(TX_BUSY),
    .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN), .RF_ADDR(RF_ADDR),
    .RF_WR_DATA(RF_WR_DATA), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  typedef enum logic [1:0] {EV_WR, EV_RD, EV_TX, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [3:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [3:0] mon_hits, mon_want;
  ev_t        mon_ev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Caller must be at a negedge; the byte is sampled on the following posedge.
  task automatic send_byte(input logic [7:0] b, input logic err);
    RX_P_DATA = b;
    RX_ERR    = err;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
    RX_ERR    = 1'b0;
  endtask

  always @(negedge CLK) begin
    mon_hits = {RF_WR_EN, RF_RD_EN, TX_D_VLD, CMD_ERR};
    if (RST && mon_hits != 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {28'd0, mon_hits}, 32'd0);
      end else begin
        mon_ev = exp_q.pop_front();
        case (mon_ev.kind)
          EV_WR:   mon_want = 4'b1000;
          EV_RD:   mon_want = 4'b0100;
          EV_TX:   mon_want = 4'b0010;
          default: mon_want = 4'b0001;
        endcase
        check("strobe_set", {28'd0, mon_hits}, {28'd0, mon_want});
        if (mon_ev.kind == EV_WR || mon_ev.kind == EV_RD)
          check("strobe_addr", {28'd0, RF_ADDR}, {28'd0, mon_ev.addr});
        if (mon_ev.kind == EV_WR)
          check("strobe_wdata", {24'd0, RF_WR_DATA}, {24'd0, mon_ev.data});
        if (mon_ev.kind == EV_TX)
          check("strobe_txdata", {24'd0, TX_P_DATA}, {24'd0, mon_ev.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic [7:0] snap_wd, snap_tx;
    logic [3:0] snap_addr;

    // Reset state
    #12;
    check("rst_wr_en",   {31'd0, RF_WR_EN}, 32'd0);
    check("rst_rd_en",   {31'd0, RF_RD_EN}, 32'd0);
    check("rst_tx_vld",  {31'd0, TX_D_VLD}, 32'd0);
    check("rst_cmd_err", {31'd0, CMD_ERR},  32'd0);
    check("rst_outputs", {12'd0, RF_ADDR, RF_WR_DATA, TX_P_DATA}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    // Write frame: addr byte 0x15 keeps only its low nibble
    exp_q.push_back('{EV_WR, 4'h5, 8'h3C});
    send_byte(8'hAA, 1'b0);
    send_byte(8'h15, 1'b0);
    send_byte(8'h3C, 1'b0);
    check("wr_pulse",  {31'd0, RF_WR_EN}, 32'd1);
    check("wr_addr",   {28'd0, RF_ADDR}, 32'h5);
    check("wr_data",   {24'd0, RF_WR_DATA}, 32'h3C);
    @(negedge CLK);
    check("wr_one_cycle", {31'd0, RF_WR_EN}, 32'd0);

    // Back-to-back frames: second 0xAA lands on the cycle the FSM is back in IDLE
    exp_q.push_back('{EV_WR, 4'h7, 8'h11});
    exp_q.push_back('{EV_WR, 4'h8, 8'h22});
    send_byte(8'hAA, 1'b0);
    send_byte(8'h07, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h22, 1'b0);
    check("b2b_wr_pulse", {31'd0, RF_WR_EN}, 32'd1);

    // Bad byte aborts, then a clean frame completes
    exp_q.push_back('{EV_ERR, 4'h0, 8'h00});
    send_byte(8'hAA, 1'b0);
    send_byte(8'h04, 1'b1);
    check("abort_cmd_err", {31'd0, CMD_ERR}, 32'd1);
    exp_q.push_back('{EV_WR, 4'h1, 8'h55});
    send_byte(8'hAA, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h55, 1'b0);
    check("after_abort_wr", {20'd0, RF_WR_EN, 3'd0, RF_ADDR, RF_WR_DATA}, {20'd0, 1'b1, 3'd0, 4'h1, 8'h55});

    // Read frame with 3-cycle register latency and a 10-cycle busy transmitter
    exp_q.push_back('{EV_RD, 4'h2, 8'h00});
    send_byte(8'hBB, 1'b0);
    send_byte(8'h02, 1'b0);
    check("rd_pulse", {27'd0, RF_RD_EN, RF_ADDR}, {27'd0, 1'b1, 4'h2});
    TX_BUSY = 1'b1;
    repeat (2) @(negedge CLK);
    RF_RD_DATA     = 8'h7E;
    RF_RD_DATA_VLD = 1'b1;
    @(negedge CLK);
    RF_RD_DATA_VLD = 1'b0;
    RF_RD_DATA     = 8'h00;
    check("rd_capture", {24'd0, TX_P_DATA}, 32'h7E);
    send_byte(8'hAA, 1'b0);
    repeat (6) @(negedge CLK);
    check("tx_held_busy", {23'd0, TX_D_VLD, TX_P_DATA}, {23'd0, 1'b0, 8'h7E});
    exp_q.push_back('{EV_TX, 4'h0, 8'h7E});
    TX_BUSY = 1'b0;
    @(negedge CLK);
    check("tx_pulse", {23'd0, TX_D_VLD, TX_P_DATA}, {23'd0, 1'b1, 8'h7E});

    // Read-data strobe outside RD_WAIT, unknown command and bad byte in IDLE
    @(negedge CLK);
    snap_addr = RF_ADDR;
    snap_wd   = RF_WR_DATA;
    snap_tx   = TX_P_DATA;
    RF_RD_DATA     = 8'h99;
    RF_RD_DATA_VLD = 1'b1;
    @(negedge CLK);
    RF_RD_DATA_VLD = 1'b0;
    send_byte(8'h12, 1'b0);
    send_byte(8'hAA, 1'b1);
    send_byte(8'h33, 1'b0);
    repeat (3) @(negedge CLK);
    check("idle_outputs_stable", {12'd0, RF_ADDR, RF_WR_DATA, TX_P_DATA},
          {12'd0, snap_addr, snap_wd, snap_tx});

    // Timeout: CMD_ERR exactly 15 cycles after entering RD_ADDR
    exp_q.push_back('{EV_ERR, 4'h0, 8'h00});
    send_byte(8'hBB, 1'b0);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (CMD_ERR) begin
        n = i;
        break;
      end
    end
    check("timeout_latency", n, 32'd15);

    // Slow frame: gaps of 13 idle cycles stay inside the timeout
    exp_q.push_back('{EV_WR, 4'hC, 8'hA5});
    send_byte(8'hAA, 1'b0);
    repeat (13) @(negedge CLK);
    send_byte(8'h0C, 1'b0);
    repeat (13) @(negedge CLK);
    send_byte(8'hA5, 1'b0);
    check("slow_wr_pulse", {31'd0, RF_WR_EN}, 32'd1);

    // Reset asserted during WR_DATA discards the frame
    @(negedge CLK);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h09, 1'b0);
    check("pre_reset_addr", {28'd0, RF_ADDR}, 32'h9);
    #2 RST = 1'b0;
    #1;
    check("mid_reset_outputs",
          {8'd0, RF_WR_EN, RF_RD_EN, TX_D_VLD, CMD_ERR, RF_ADDR, RF_WR_DATA, TX_P_DATA}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    send_byte(8'h5A, 1'b0);
    check("post_reset_no_wr", {31'd0, RF_WR_EN}, 32'd0);
    repeat (20) @(negedge CLK);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_cmd_ctrl.md
UART_RX_CMD_CTRL -- requirements
Module: uart_rx_cmd_ctrl

Interface
- REQ-001: The module SHALL have parameter DATA_WIDTH, default 8, giving the width of the UART byte and register data.
- REQ-002: The module SHALL have parameter ADDR_WIDTH, default 4, giving the register-file address width.
- REQ-003: The module SHALL have parameter TIMEOUT, default 1024, giving the maximum idle clock cycles tolerated inside a frame.
- REQ-004: Port CLK, input, 1 bit: the single clock; all state SHALL change on its rising edge.
- REQ-005: Port RST, input, 1 bit: reset, asynchronous and active-low.
- REQ-006: Port RX_P_DATA, input, DATA_WIDTH bits: received byte from the UART receiver.
- REQ-007: Port RX_D_VLD, input, 1 bit: one-cycle strobe marking RX_P_DATA valid.
- REQ-008: Port RX_ERR, input, 1 bit: parity or stop error for the byte strobed by RX_D_VLD.
- REQ-009: Port RF_RD_DATA, input, DATA_WIDTH bits: register-file read data.
- REQ-010: Port RF_RD_DATA_VLD, input, 1 bit: strobe marking RF_RD_DATA valid.
- REQ-011: Port TX_BUSY, input, 1 bit: high while the UART transmitter cannot accept a byte.
- REQ-012: Port RF_WR_EN, output, 1 bit: register-file write strobe.
- REQ-013: Port RF_RD_EN, output, 1 bit: register-file read strobe.
- REQ-014: Port RF_ADDR, output, ADDR_WIDTH bits: register-file address.
- REQ-015: Port RF_WR_DATA, output, DATA_WIDTH bits: register-file write data.
- REQ-016: Port TX_P_DATA, output, DATA_WIDTH bits: byte sent to the transmitter.
- REQ-017: Port TX_D_VLD, output, 1 bit: transmit request strobe.
- REQ-018: Port CMD_ERR, output, 1 bit: one-cycle pulse when a frame is aborted.

Function
- REQ-019: A "good byte" SHALL mean RX_D_VLD=1 with RX_ERR=0; a "bad byte" SHALL mean RX_D_VLD=1 with RX_ERR=1.
- REQ-020: The FSM SHALL have states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT and TX_REQ.
- REQ-021: All outputs SHALL be registered.
- REQ-022: In IDLE, a good byte 0xAA SHALL move the FSM to WR_ADDR, a good byte 0xBB SHALL move it to RD_ADDR, and any other byte (good or bad) SHALL leave it in IDLE with no CMD_ERR.
- REQ-023: In WR_ADDR, a good byte SHALL latch its bits [ADDR_WIDTH-1:0] into RF_ADDR (upper bits ignored) and move the FSM to WR_DATA.
- REQ-024: In WR_DATA, a good byte SHALL set RF_WR_DATA to that byte and RF_WR_EN=1 for exactly one cycle, starting the cycle after the strobe, and SHALL return the FSM to IDLE.
- REQ-025: In RD_ADDR, a good byte SHALL latch RF_ADDR, set RF_RD_EN=1 for exactly one cycle starting the cycle after the strobe, and move the FSM to RD_WAIT.
- REQ-026: In RD_WAIT, RF_RD_DATA_VLD=1 SHALL capture RF_RD_DATA into TX_P_DATA and move the FSM to TX_REQ.
- REQ-027: In TX_REQ, on the first cycle with TX_BUSY=0 the block SHALL set TX_D_VLD=1 for exactly one cycle and return the FSM to IDLE; TX_P_DATA SHALL be held stable until then.
- REQ-028: A bad byte in WR_ADDR, WR_DATA or RD_ADDR SHALL abort the frame: FSM to IDLE, CMD_ERR pulsed one cycle, no RF strobe issued.
- REQ-029: The timeout counter SHALL clear on entry to WR_ADDR, WR_DATA, RD_ADDR and RD_WAIT, and on each strobe in those states.
- REQ-030: The timeout counter SHALL otherwise increment in those states; reaching TIMEOUT-1 SHALL abort the frame: FSM to IDLE, CMD_ERR pulsed.
- REQ-031: TX_REQ SHALL have no timeout.
- REQ-032: RX_D_VLD SHALL be ignored in RD_WAIT and TX_REQ (bytes dropped, no error).
- REQ-033: RF_RD_DATA_VLD outside RD_WAIT SHALL be ignored.
- REQ-034: The strobes RF_WR_EN, RF_RD_EN, TX_D_VLD and CMD_ERR SHALL be mutually exclusive in any cycle.
- REQ-035: Back-to-back frames SHALL be accepted: a 0xAA strobe arriving in the cycle the FSM returns to IDLE SHALL be decoded.

Reset
- REQ-036: RST=0 SHALL asynchronously force the FSM to IDLE and clear the timeout counter.
- REQ-037: RST=0 SHALL asynchronously drive all outputs to 0 (RF_ADDR, RF_WR_DATA and TX_P_DATA to 0; all strobes low).
- REQ-038: Reset asserted mid-frame SHALL discard the frame with no strobe emitted after release.

Verification
- REQ-039: Write frame: strobe good bytes 0xAA, 0x15, 0x3C -> one RF_WR_EN pulse with RF_ADDR=0x5 and RF_WR_DATA=0x3C, then FSM in IDLE.
- REQ-040: Read frame: strobe 0xBB, 0x02; return RF_RD_DATA=0x7E with VLD after 3 cycles; hold TX_BUSY=1 for 10 cycles -> one RF_RD_EN pulse with RF_ADDR=0x2; TX_D_VLD pulses once with TX_P_DATA=0x7E in the first cycle after TX_BUSY falls.
- REQ-041: Strobe 0xAA, then 0x04 with RX_ERR=1 -> CMD_ERR pulse, no RF_WR_EN; a following good frame 0xAA, 0x01, 0x55 completes normally.
- REQ-042: Timeout: with TIMEOUT=16, strobe 0xBB and then no bytes -> CMD_ERR pulses exactly 15 cycles after the state entry, no RF_RD_EN.
- REQ-043: Strobe an unknown command 0x12 -> no outputs change; assert RST during WR_DATA -> all outputs 0 and no RF_WR_EN after release.
